pa_spsram_cfg: RTL and testbench



---
 rtl/pa_spsram_cfg_pkg.sv | 21 ++
 rtl/pa_spsram_cfg_if.sv | 28 ++
 rtl/pa_spsram_init_ctrl.sv | 76 +++++++
 rtl/pa_spsram_cfg.sv | 118 +++++++++++
 tb/tb_pa_spsram_cfg.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pa_spsram_cfg_pkg.sv
// Shared definitions for the configurable single-port SRAM wrapper:
// init sequencer state encoding and write-mask lane geometry helpers.
package pa_spsram_cfg_pkg;

  // Init sequencer: sweeping the array, or open for user traffic.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  // Width of one write-mask lane.
  function automatic int lane_width(input int data_width, input int we_width);
    return data_width / we_width;
  endfunction

  // Lanes must tile the entry exactly; a remainder would leave bits unmaskable.
  function automatic bit lane_cfg_ok(input int data_width, input int we_width);
    return (we_width > 0) && ((data_width % we_width) == 0);
  endfunction

endpackage

// File: rtl/pa_spsram_cfg_if.sv
// Array-controller <-> SRAM wrapper bus. Macro-style active-low controls.
interface pa_spsram_cfg_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 44,
  parameter int WE_WIDTH   = 44
);

  logic [ADDR_WIDTH-1:0] A;
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [DATA_WIDTH-1:0] D;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_DONE;

  // Array controller side.
  modport master (
    output A, CEN, GWEN, WEN, D,
    input  Q, INIT_DONE
  );

  // SRAM wrapper side.
  modport slave (
    input  A, CEN, GWEN, WEN, D,
    output Q, INIT_DONE
  );

endinterface

// File: rtl/pa_spsram_init_ctrl.sv
// Post-reset clear sequencer: walks cnt over every entry once, asserting a
// full-mask write each edge, then parks in READY until the next reset.
module pa_spsram_init_ctrl
  import pa_spsram_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int INIT_EN    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  if (INIT_EN != 0) begin : g_sweep
    init_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // State and sweep counter register; reset restarts the sweep at entry 0.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= INIT;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next state, counter advance and sweep write strobe. The last entry is
    // written on the same edge that enters READY, so cnt never wraps.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      init_we = 1'b0;
      case (state_q)
        INIT: begin
          init_we = ~RST;
          if (cnt_q == LAST_ADDR) begin
            state_d = READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        READY: begin
          state_d = READY;
        end
        default: begin
          state_d = INIT;
        end
      endcase
    end

    assign init_addr = cnt_q;
    assign init_done = (state_q == READY);
  end else begin : g_nosweep
    logic done_q;

    // Without a sweep the array is usable from the first edge after reset.
    always_ff @(posedge CLK) begin
      if (RST) begin
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b1;
      end
    end

    assign init_we   = 1'b0;
    assign init_addr = '0;
    assign init_done = done_q;
  end

endmodule

// File: rtl/pa_spsram_cfg.sv
// Parametrised single-port SRAM wrapper for tag/data arrays: lane-masked
// writes, registered read with optional extra output stage, and a
// post-reset clear sweep gating user access through INIT_DONE.
module pa_spsram_cfg
  import pa_spsram_cfg_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 44,
  parameter int                    WE_WIDTH   = 44,
  parameter int                    OUT_REG    = 0,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic             CLK,
  input logic             RST,
  pa_spsram_cfg_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = lane_width(DATA_WIDTH, WE_WIDTH);

  if (!lane_cfg_ok(DATA_WIDTH, WE_WIDTH)) begin : g_bad_lane_cfg
    $error("pa_spsram_cfg: DATA_WIDTH must be a multiple of WE_WIDTH");
  end

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic                  init_done;

  logic                  user_take;
  logic                  user_wr;
  logic                  user_rd;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [WE_WIDTH-1:0]   wr_lane;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] q_p0;

  pa_spsram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_EN    (INIT_EN)
  ) u_init_ctrl (
    .CLK       (CLK),
    .RST       (RST),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  assign bus.INIT_DONE = init_done;

  // Access qualification and init/user write mux. Requests arriving before
  // the array is ready or during reset are dropped outright.
  always_comb begin
    user_take = ~bus.CEN & init_done & ~RST;
    user_wr   = user_take & ~bus.GWEN;
    user_rd   = user_take & bus.GWEN;
    wr_en     = init_we | user_wr;
    wr_addr   = bus.A;
    wr_data   = bus.D;
    wr_lane   = ~bus.WEN;
    if (init_we) begin
      wr_addr = init_addr;
      wr_data = INIT_VALUE;
      wr_lane = '1;
    end
  end

  // Lane-masked storage write; reset never touches the contents.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (wr_lane[i]) begin
          mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
        end
      end
    end
  end

  // ---- stage p0: storage read register, holds when no read is taken ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_p0 <= '0;
    end else if (user_rd) begin
      q_p0 <= mem[bus.A];
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_p0;
    logic [DATA_WIDTH-1:0] q_p1;

    // Tracks whether q_p0 was loaded by a read on the last edge.
    always_ff @(posedge CLK) begin
      if (RST) begin
        vld_p0 <= 1'b0;
      end else begin
        vld_p0 <= user_rd;
      end
    end

    // ---- stage p1: output register, loads only behind a fresh read ----
    always_ff @(posedge CLK) begin
      if (RST) begin
        q_p1 <= '0;
      end else if (vld_p0) begin
        q_p1 <= q_p0;
      end
    end

    assign bus.Q = q_p1;
  end else begin : g_no_out_reg
    assign bus.Q = q_p0;
  end

endmodule

// File: tb/tb_pa_spsram_cfg.sv
// Directed bench for pa_spsram_cfg: default configuration (u_dut0) and an
// OUT_REG=1, 11-lane, INIT_VALUE=0xABC configuration (u_dut1) on one clock.
module tb_pa_spsram_cfg;

  logic CLK;
  logic RST;

  int checks = 0;
  int errors = 0;

  pa_spsram_cfg_if #(.ADDR_WIDTH(6), .DATA_WIDTH(44), .WE_WIDTH(44)) bus0 ();
  pa_spsram_cfg_if #(.ADDR_WIDTH(6), .DATA_WIDTH(44), .WE_WIDTH(11)) bus1 ();

  pa_spsram_cfg #(
    .ADDR_WIDTH(6), .DATA_WIDTH(44), .WE_WIDTH(44),
    .OUT_REG(0), .INIT_EN(1), .INIT_VALUE(44'h0)
  ) u_dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0.slave)
  );

  pa_spsram_cfg #(
    .ADDR_WIDTH(6), .DATA_WIDTH(44), .WE_WIDTH(11),
    .OUT_REG(1), .INIT_EN(1), .INIT_VALUE(44'hABC)
  ) u_dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle0();
    bus0.CEN = 1'b1; bus0.GWEN = 1'b1; bus0.WEN = '1; bus0.A = '0; bus0.D = '0;
  endtask

  task automatic idle1();
    bus1.CEN = 1'b1; bus1.GWEN = 1'b1; bus1.WEN = '1; bus1.A = '0; bus1.D = '0;
  endtask

  task automatic wr0(input logic [5:0] a, input logic [43:0] d, input logic [43:0] wen);
    bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.A = a; bus0.D = d; bus0.WEN = wen;
    tick();
    idle0();
  endtask

  task automatic rd0(input logic [5:0] a);
    bus0.CEN = 1'b0; bus0.GWEN = 1'b1; bus0.A = a; bus0.D = '0; bus0.WEN = '0;
    tick();
    idle0();
  endtask

  // Counts edges from release until both arrays report ready (bounded).
  task automatic sweep(output int e0, output int e1, output bit qchg, input bit poke);
    int e;
    e = 0; e0 = 0; e1 = 0; qchg = 1'b0;
    while ((e0 == 0 || e1 == 0) && e < 200) begin
      if (poke && e == 9) begin
        bus0.CEN = 1'b0; bus0.GWEN = 1'b0; bus0.WEN = '0; bus0.A = 6'd2; bus0.D = 44'h123;
      end else if (poke && e == 10) begin
        idle0();
      end
      tick();
      e++;
      if (bus0.INIT_DONE && e0 == 0) e0 = e;
      if (bus1.INIT_DONE && e1 == 0) e1 = e;
      if (bus0.Q !== 44'h0) qchg = 1'b1;
    end
  endtask

  int  e0, e1;
  bit  qchg;

  initial begin
    RST = 1'b1;
    idle0();
    idle1();
    repeat (3) tick();
    chk("rst_q0",    bus0.Q,         48'h0);
    chk("rst_done0", bus0.INIT_DONE, 48'h0);
    chk("rst_q1",    bus1.Q,         48'h0);
    chk("rst_done1", bus1.INIT_DONE, 48'h0);

    // Reset sweep with a write poked at edge 10 that must be dropped.
    RST = 1'b0;
    sweep(e0, e1, qchg, 1'b1);
    chk("sweep_edges0", 48'(e0), 48'd64);
    chk("sweep_edges1", 48'(e1), 48'd64);
    chk("sweep_q_quiet", 48'(qchg), 48'd0);

    rd0(6'd0);  chk("rd0_a0",  bus0.Q, 48'h0);
    rd0(6'd31); chk("rd0_a31", bus0.Q, 48'h0);
    rd0(6'd63); chk("rd0_a63", bus0.Q, 48'h0);
    rd0(6'd2);  chk("drop_wr_a2", bus0.Q, 48'h0);

    // Masked write: full fill, then clear only lanes 3..0.
    wr0(6'd5, 44'hFFF_FFFF_FFFF, 44'h0);
    wr0(6'd5, 44'h0, ~44'hF);
    rd0(6'd5);  chk("mask_a5", bus0.Q, 48'hFFF_FFFF_FFF0);

    // Write/read turnaround; Q must not move on the write edge.
    wr0(6'd7, 44'h5A5, 44'h0);
    chk("wr_q_hold", bus0.Q, 48'hFFF_FFFF_FFF0);
    rd0(6'd7);  chk("turn_a7", bus0.Q, 48'h5A5);
    repeat (2) tick();
    chk("cen_hold0", bus0.Q, 48'h5A5);

    // OUT_REG=1 config: lane write of lanes 1..0 on A=3 over 0xABC.
    bus1.CEN = 1'b0; bus1.GWEN = 1'b0; bus1.A = 6'd3;
    bus1.D = 44'hFFF_FFFF_FFFF; bus1.WEN = 11'b111_1111_1100;
    tick();
    chk("wr1_q_hold", bus1.Q, 48'h0);
    bus1.GWEN = 1'b1; bus1.WEN = '0; bus1.D = '0;
    bus1.A = 6'd1; tick(); chk("or_lat_e1", bus1.Q, 48'h0);
    bus1.A = 6'd2; tick(); chk("or_a1_e2",  bus1.Q, 48'hABC);
    bus1.A = 6'd3; tick(); chk("or_a2_e3",  bus1.Q, 48'hABC);
    idle1();       tick(); chk("or_a3_e4",  bus1.Q, 48'hAFF);
    repeat (3) tick();
    chk("cen_hold1", bus1.Q, 48'hAFF);

    // Reset mid-sweep: pulse at edge 30, full 64-edge sweep after release.
    RST = 1'b1;
    tick();
    chk("rst2_done0", bus0.INIT_DONE, 48'h0);
    chk("rst2_q0",    bus0.Q,         48'h0);
    chk("rst2_q1",    bus1.Q,         48'h0);
    RST = 1'b0;
    repeat (29) tick();
    chk("mid_done0", bus0.INIT_DONE, 48'h0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sweep(e0, e1, qchg, 1'b0);
    chk("resweep_edges0", 48'(e0), 48'd64);
    chk("resweep_edges1", 48'(e1), 48'd64);
    rd0(6'd7);  chk("resweep_a7", bus0.Q, 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
